// File: rtl/oka_seq_mul.sv
// Folded carry-less multiplier: one odd/even Karatsuba level, with the three
// half-width sub-products computed in turn on a shared digit-serial core.
module oka_seq_mul #(
  parameter int WIDTH = 128,
  parameter int DIGIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-2:0] y,
  output logic               busy
);

  localparam int H  = WIDTH / 2;
  localparam int S  = H / DIGIT;
  localparam int PW = 2 * H - 1;
  localparam int YW = 2 * WIDTH - 1;
  localparam int CW = (S > 1) ? $clog2(S) : 1;
  localparam logic [CW-1:0] LAST = CW'(S - 1);

  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [H-1:0]    al_q, ah_q, aa_q, bl_q, bh_q, bb_q;
  logic [H-1:0]    al_d, ah_d, bl_d, bh_d;
  logic [PW-1:0]   acc, z0, z1, z2;
  logic [H-1:0]    a_sel, b_sel, b_shift;
  logic [DIGIT-1:0] digit;
  logic [PW-1:0]   pp, acc_next, m;
  logic [YW-1:0]   y_next;
  logic            accept;

  // Interleave v into the even bit positions of a full-width product.
  function automatic logic [YW-1:0] spread(input logic [PW-1:0] v);
    logic [YW-1:0] r;
    r = '0;
    for (int j = 0; j < PW; j++) r[2*j] = v[j];
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < H; i++) begin
      al_d[i] = a[2*i];
      ah_d[i] = a[2*i+1];
      bl_d[i] = b[2*i];
      bh_d[i] = b[2*i+1];
    end
  end

  assign accept = (state == IDLE) && in_valid && !rst;

  // NOTE: operand registers carry no reset; they are only read after an
  // accept has overwritten them, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      al_q <= al_d;
      ah_q <= ah_d;
      aa_q <= al_d ^ ah_d;
      bl_q <= bl_d;
      bh_q <= bh_d;
      bb_q <= bl_d ^ bh_d;
    end
  end

  // NOTE: every variable gets a default at the top so no path infers a latch.
  always_comb begin
    a_sel = al_q;
    b_sel = bl_q;
    case (state)
      MUL1:    begin a_sel = aa_q; b_sel = bb_q; end
      MUL2:    begin a_sel = ah_q; b_sel = bh_q; end
      default: begin a_sel = al_q; b_sel = bl_q; end
    endcase
    b_shift = b_sel >> (DIGIT * int'(cnt));
    digit   = b_shift[DIGIT-1:0];
    pp      = '0;
    for (int i = 0; i < DIGIT; i++)
      if (digit[i]) pp = pp ^ (PW'(a_sel) << i);
    acc_next = acc ^ (pp << (DIGIT * int'(cnt)));
    // acc_next is the finished z2 on the last MUL2 step.
    m      = z1 ^ z0 ^ acc_next;
    y_next = spread(z0) ^ (spread(m) << 1) ^ (spread(acc_next) << 2);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      z0        <= '0;
      z1        <= '0;
      z2        <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= MUL0;
            cnt      <= '0;
            acc      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        MUL0, MUL1, MUL2: begin
          if (cnt == LAST) begin
            cnt <= '0;
            acc <= '0;
            case (state)
              MUL0: begin z0 <= acc_next; state <= MUL1; end
              MUL1: begin z1 <= acc_next; state <= MUL2; end
              default: begin
                z2        <= acc_next;
                y         <= y_next;
                out_valid <= 1'b1;
                state     <= DONE;
              end
            endcase
          end else begin
            cnt <= cnt + 1'b1;
            acc <= acc_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oka_seq_mul.sv
// Directed bench for oka_seq_mul at three geometries sharing one clock/reset.
module tb_oka_seq_mul;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=8, DIGIT=2
  logic        iv8 = 0, ir8, ov8, or8 = 0, bz8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [14:0] y8;
  // WIDTH=128, DIGIT=8
  logic         iv128 = 0, ir128, ov128, or128 = 0, bz128;
  logic [127:0] a128 = 0, b128 = 0;
  logic [254:0] y128;
  // WIDTH=64, DIGIT=32
  logic         iv64 = 0, ir64, ov64, or64 = 0, bz64;
  logic [63:0]  a64 = 0, b64 = 0;
  logic [126:0] y64;

  oka_seq_mul #(.WIDTH(8), .DIGIT(2)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .y(y8), .busy(bz8));
  oka_seq_mul #(.WIDTH(128), .DIGIT(8)) u128 (
    .clk(clk), .rst(rst), .in_valid(iv128), .in_ready(ir128), .a(a128), .b(b128),
    .out_valid(ov128), .out_ready(or128), .y(y128), .busy(bz128));
  oka_seq_mul #(.WIDTH(64), .DIGIT(32)) u64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
    .out_valid(ov64), .out_ready(or64), .y(y64), .busy(bz64));

  task automatic check(input string tag, input logic [254:0] obs, input logic [254:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Schoolbook shift-and-xor reference, independent of any splitting.
  function automatic logic [254:0] clmul_ref(input logic [127:0] x, input logic [127:0] z);
    logic [254:0] r;
    r = '0;
    for (int i = 0; i < 128; i++)
      if (z[i]) r = r ^ ({127'b0, x} << i);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start8(input logic [7:0] av, input logic [7:0] bv);
    iv8 = 1; a8 = av; b8 = bv;
    check("w8_in_ready_idle", 255'(ir8), 255'(1));
    step();
    iv8 = 0; a8 = ~av; b8 = ~bv;
  endtask

  task automatic wait8(input string tag, input logic [14:0] exp);
    int n = 0;
    do begin
      step();
      n++;
      if (!ov8) check("w8_in_ready_busy", 255'(ir8), 255'(0));
    end while (!ov8 && n < 40);
    check({tag, "_latency"}, 255'(n), 255'(6));
    check({tag, "_y"}, 255'(y8), 255'(exp));
    check({tag, "_in_ready_done"}, 255'(ir8), 255'(0));
  endtask

  task automatic release8(input int hold, input logic [14:0] exp);
    for (int i = 0; i < hold; i++) begin
      step();
      check("w8_stall_valid", 255'(ov8), 255'(1));
      check("w8_stall_y", 255'(y8), 255'(exp));
      check("w8_stall_in_ready", 255'(ir8), 255'(0));
    end
    or8 = 1;
    step();
    or8 = 0;
    check("w8_release_valid", 255'(ov8), 255'(0));
    check("w8_release_in_ready", 255'(ir8), 255'(1));
    check("w8_release_busy", 255'(bz8), 255'(0));
    check("w8_y_held", 255'(y8), 255'(exp));
  endtask

  task automatic txn128(input logic [127:0] av, input logic [127:0] bv, input int gap);
    int n = 0;
    logic [254:0] exp;
    exp = clmul_ref(av, bv);
    iv128 = 1; a128 = av; b128 = bv;
    if (!ir128) check("w128_in_ready_idle", 255'(ir128), 255'(1));
    step();
    iv128 = 0; a128 = $urandom; b128 = $urandom;
    do begin
      step();
      n++;
    end while (!ov128 && n < 60);
    check("w128_latency", 255'(n), 255'(24));
    check("w128_y", y128, exp);
    for (int i = 0; i < gap; i++) step();
    if (gap > 0) check("w128_y_stall", y128, exp);
    or128 = 1;
    step();
    or128 = 0;
  endtask

  initial begin
    int n;
    step();
    step();
    rst = 0;
    check("reset_in_ready", 255'(ir8), 255'(1));
    check("reset_busy", 255'(bz8), 255'(0));
    check("reset_out_valid", 255'(ov8), 255'(0));
    check("reset_y", 255'(y8), 255'(0));

    // out_ready while idle must be ignored
    or8 = 1;
    step();
    or8 = 0;
    check("idle_out_ready_noop", 255'(ov8), 255'(0));

    start8(8'h57, 8'h83); wait8("t57x83", 15'h2B79); release8(0, 15'h2B79);
    start8(8'hFF, 8'hFF); wait8("tFFxFF", 15'h5555); release8(0, 15'h5555);
    start8(8'h80, 8'h80); wait8("t80x80", 15'h4000); release8(0, 15'h4000);
    start8(8'h00, 8'hA5); wait8("t00xA5", 15'h0000); release8(0, 15'h0000);

    // Backpressure
    start8(8'h57, 8'h83); wait8("bp", 15'h2B79); release8(10, 15'h2B79);

    // Reset during MUL1 (S=2: two MUL0 steps after accept)
    start8(8'h12, 8'h34);
    step();
    step();
    check("mid_busy", 255'(bz8), 255'(1));
    rst = 1;
    step();
    rst = 0;
    check("mid_rst_valid", 255'(ov8), 255'(0));
    check("mid_rst_y", 255'(y8), 255'(0));
    check("mid_rst_busy", 255'(bz8), 255'(0));
    check("mid_rst_in_ready", 255'(ir8), 255'(1));
    n = 0;
    repeat (8) begin
      step();
      if (ov8) n++;
    end
    check("mid_rst_no_valid", 255'(n), 255'(0));
    start8(8'h03, 8'h03); wait8("t03x03", 15'h0005); release8(0, 15'h0005);

    // Reset while in DONE
    start8(8'h57, 8'h83); wait8("done_rst", 15'h2B79);
    rst = 1;
    step();
    rst = 0;
    check("done_rst_valid", 255'(ov8), 255'(0));
    check("done_rst_y", 255'(y8), 255'(0));
    check("done_rst_in_ready", 255'(ir8), 255'(1));

    // WIDTH=64, DIGIT=32: single-step sub-products
    iv64 = 1; a64 = 64'h8000_0000_0000_0000; b64 = 64'h8000_0000_0000_0000;
    step();
    iv64 = 0; a64 = 0; b64 = 0;
    n = 0;
    do begin
      step();
      n++;
    end while (!ov64 && n < 20);
    check("w64_latency", 255'(n), 255'(3));
    check("w64_y", 255'(y64), 255'(1) << 126);
    or64 = 1;
    step();
    or64 = 0;
    check("w64_release_in_ready", 255'(ir64), 255'(1));

    // WIDTH=128 corners, then random pairs with random out_ready gaps
    txn128('1, '1, 0);
    txn128(128'h1, {1'b1, 127'b0}, 2);
    for (int t = 0; t < 1000; t++)
      txn128({$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oka_seq_mul.md
# oka_seq_mul

Parametrised, folded, sequential carry-less (GF(2)[x]) multiplier that applies one level of odd/even Karatsuba splitting and computes the three half-width sub-products on a single shared digit-serial core. It is the area-optimised, handshaked successor to the fully unrolled combinational OKA multiplier tree. It sits between operand staging and downstream reduction or accumulation logic. It accepts one operand pair per transaction through a valid/ready handshake and returns the unreduced 2·WIDTH−1-bit product.

## Interface
- WIDTH, 128: operand width in bits; even, ≥4.
- DIGIT, 8: b-digit bits consumed per cycle by the core; must divide WIDTH/2.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept an operand pair.
- a  in  WIDTH  operand polynomial, bit i = coefficient of x^i.
- b  in  WIDTH  operand polynomial.
- out_valid  out  1  y holds a completed product.
- out_ready  in  1  consumer accepts y.
- y  out  2·WIDTH−1  carry-less product a·b (unreduced).
- busy  out  1  high in any state other than IDLE.

## Operation
- Define H = WIDTH/2 and S = H/DIGIT.
- Odd/even split, index i<H: al[i]=a[2i], ah[i]=a[2i+1], aa=al^ah. bl, bh, bb are formed from b the same way.
- On accept, the block latches al, ah, aa, bl, bh, bb.
- Sub-products, each 2H−1 bits: z0=al·bl, z1=aa·bb, z2=ah·bh (carry-less).
- Core step k (0..S−1): acc ^= (A · B[k·DIGIT +: DIGIT]) << (k·DIGIT). acc is cleared at the start of each sub-product.
- Combine: spread(v) places v[j] at bit 2j. m = z1^z0^z2. y = spread(z0) ^ (spread(m)<<1) ^ (spread(z2)<<2), truncated to 2·WIDTH−1 bits.
- FSM states: IDLE, MUL0, MUL1, MUL2, DONE.
  - IDLE: in_ready=1. On in_valid, latch operands, go to MUL0, step counter=0.
  - MUL0: one core step per cycle. After step S−1, store z0, clear acc, go to MUL1.
  - MUL1: same as MUL0, stores z1, then goes to MUL2.
  - MUL2: same, producing z2. On its final step the combine uses the final z2 value directly, registers y, and goes to DONE.
  - DONE: out_valid=1, y held stable. On out_ready, go to IDLE.
- in_ready=0 in every state except IDLE. a and b are ignored outside the IDLE accept cycle.
- y is held unchanged after the handshake until the next product is registered.

## Timing
- Reset (rst=1 at an edge): state=IDLE, counter=0, acc=z0=z1=z2=0, y=0, out_valid=0, busy=0. in_ready=1 from the first cycle after reset.
- Reset mid-operation: the transaction is abandoned and no out_valid is produced.
- Reset while in DONE: out_valid drops on that edge and y clears.
- rst has priority over all handshake inputs.
- Latency: accept at edge E0; out_valid is high from edge E0+3·S. Defaults give 24 cycles; WIDTH=8, DIGIT=2 gives 6.
- Throughput: at most one transaction per 3·S+2 cycles when out_ready is held high.
  - DONE lasts 1 cycle, then 1 cycle in IDLE.
  - No back-to-back accept in DONE.
- out_ready high while not in DONE has no effect.
- out_valid stalls indefinitely with y stable while out_ready=0.
- in_valid may be deasserted while in_ready=0 without effect. Transactions are not queued.

## Test plan
- WIDTH=8, DIGIT=2, a=0x57, b=0x83 -> y=0x2B79; out_valid rises exactly 6 edges after accept; in_ready=0 throughout.
- WIDTH=8, DIGIT=2, a=0xFF, b=0xFF -> y=0x5555. Then a=0x80, b=0x80 -> y=0x4000. Then a=0x00, b=0xA5 -> y=0x0000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> y and out_valid stable, in_ready=0. Release -> IDLE next edge, in_ready=1.
- Reset: assert rst during MUL1 -> next edge out_valid=0, y=0, busy=0, in_ready=1. A subsequent a=0x03, b=0x03 -> y=0x0005 with normal latency.
- WIDTH=128, DIGIT=8, 1000 random pairs with random out_ready gaps -> y matches a bitwise clmul reference model; every out_valid occurs 24 edges after its accept.
- WIDTH=64, DIGIT=32: a=b=2^63 -> y=2^126; latency 3 edges.
